// File: rtl/maze_walker_if.sv
// Command, position/stack status and replay handshake bundle between the
// mouse controller and its position/path-stack datapath.
interface maze_walker_if #(
    parameter int COORD_W = 4,
    parameter int DEPTH   = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               cmd_step;
    logic [1:0]         move;
    logic               cmd_back;
    logic               cmd_replay;
    logic               replay_ready;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic [1:0]         top_move;
    logic [CNT_W-1:0]   count;
    logic               empty;
    logic               full;
    logic               bound_err;
    logic               stack_err;
    logic               replay_valid;
    logic [1:0]         replay_move;
    logic               replay_done;

    modport master (
        output cmd_step, move, cmd_back, cmd_replay, replay_ready,
        input  pos_x, pos_y, top_move, count, empty, full,
               bound_err, stack_err, replay_valid, replay_move, replay_done
    );

    modport slave (
        input  cmd_step, move, cmd_back, cmd_replay, replay_ready,
        output pos_x, pos_y, top_move, count, empty, full,
               bound_err, stack_err, replay_valid, replay_move, replay_done
    );
endinterface

// File: rtl/maze_walker_datapath.sv
// Maze mouse position register with bounded single-step moves, a LIFO path
// stack for backtracking, and oldest-first handshaked replay of the path.
module maze_walker_datapath #(
    parameter int COORD_W = 4,
    parameter int DEPTH   = 16,
    parameter int MAX_X   = 15,
    parameter int MAX_Y   = 15,
    parameter int START_X = 0,
    parameter int START_Y = 0
) (
    input  logic          clk,
    input  logic          rst,
    maze_walker_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Two spare bits so a step below zero or past 2^COORD_W-1 stays visible.
    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] ONE_S    = SW'(1);
    localparam logic signed [SW-1:0] LIM_X    = SW'(MAX_X);
    localparam logic signed [SW-1:0] LIM_Y    = SW'(MAX_Y);
    localparam logic [CW-1:0]        ONE_CNT  = CW'(1);
    localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);

    typedef enum logic {WALK, REPLAY} state_t;

    state_t             state_p1, state_p0;
    logic [COORD_W-1:0] pos_x_p1, pos_x_p0;
    logic [COORD_W-1:0] pos_y_p1, pos_y_p0;
    logic [CW-1:0]      count_p1, count_p0;
    logic [AW-1:0]      rd_ptr_p1, rd_ptr_p0;
    logic               bound_err_p1, bound_err_p0;
    logic               stack_err_p1, stack_err_p0;
    logic               replay_done_p1, replay_done_p0;
    logic               push_p0;

    logic [1:0]         mem [DEPTH];
    logic [CW-1:0]      top_cnt;
    logic [1:0]         top_move;
    logic               empty;
    logic               full;
    logic               last_beat;
    logic               step_legal;
    logic signed [SW-1:0] tgt_x, tgt_y, back_x, back_y;

    function automatic logic signed [SW-1:0] move_coord(
        input logic [COORD_W-1:0] cur,
        input logic [1:0]         mv,
        input logic               is_x
    );
        logic signed [SW-1:0] base;
        base = $signed({2'b00, cur});
        case (mv)
            2'b00:   return is_x ? base : base + ONE_S;
            2'b01:   return is_x ? base + ONE_S : base;
            2'b10:   return is_x ? base - ONE_S : base;
            default: return is_x ? base : base - ONE_S;
        endcase
    endfunction

    function automatic logic in_range(
        input logic signed [SW-1:0] v,
        input logic signed [SW-1:0] lim
    );
        return !v[SW-1] && (v <= lim);
    endfunction

    assign top_cnt    = count_p1 - ONE_CNT;
    assign empty      = (count_p1 == '0);
    assign full       = (count_p1 == FULL_CNT);
    assign top_move   = empty ? 2'b00 : mem[top_cnt[AW-1:0]];
    assign last_beat  = ({1'b0, rd_ptr_p1} == top_cnt);

    assign tgt_x      = move_coord(pos_x_p1, bus.move, 1'b1);
    assign tgt_y      = move_coord(pos_y_p1, bus.move, 1'b0);
    // Backtrack applies the bitwise inverse of the newest move code.
    assign back_x     = move_coord(pos_x_p1, ~top_move, 1'b1);
    assign back_y     = move_coord(pos_y_p1, ~top_move, 1'b0);
    assign step_legal = in_range(tgt_x, LIM_X) && in_range(tgt_y, LIM_Y);

    // Stage p0: next-state decode from registered state and this cycle's command
    always_comb begin
        state_p0       = state_p1;
        pos_x_p0       = pos_x_p1;
        pos_y_p0       = pos_y_p1;
        count_p0       = count_p1;
        rd_ptr_p0      = rd_ptr_p1;
        bound_err_p0   = 1'b0;
        stack_err_p0   = 1'b0;
        replay_done_p0 = 1'b0;
        push_p0        = 1'b0;
        case (state_p1)
            WALK: begin
                if (bus.cmd_replay) begin
                    if (!empty) begin
                        state_p0  = REPLAY;
                        rd_ptr_p0 = '0;
                    end else begin
                        replay_done_p0 = 1'b1;
                    end
                end else if (bus.cmd_back) begin
                    if (empty) begin
                        stack_err_p0 = 1'b1;
                    end else begin
                        pos_x_p0 = back_x[COORD_W-1:0];
                        pos_y_p0 = back_y[COORD_W-1:0];
                        count_p0 = top_cnt;
                    end
                end else if (bus.cmd_step) begin
                    if (!step_legal) begin
                        bound_err_p0 = 1'b1;
                    end else if (full) begin
                        stack_err_p0 = 1'b1;
                    end else begin
                        pos_x_p0 = tgt_x[COORD_W-1:0];
                        pos_y_p0 = tgt_y[COORD_W-1:0];
                        count_p0 = count_p1 + ONE_CNT;
                        push_p0  = 1'b1;
                    end
                end
            end
            REPLAY: begin
                if (bus.replay_ready) begin
                    if (last_beat) begin
                        state_p0       = WALK;
                        rd_ptr_p0      = '0;
                        replay_done_p0 = 1'b1;
                    end else begin
                        rd_ptr_p0 = rd_ptr_p1 + 1'b1;
                    end
                end
            end
        endcase
    end

    // Stage p1: registered state and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1       <= WALK;
            pos_x_p1       <= COORD_W'(START_X);
            pos_y_p1       <= COORD_W'(START_Y);
            count_p1       <= '0;
            rd_ptr_p1      <= '0;
            bound_err_p1   <= 1'b0;
            stack_err_p1   <= 1'b0;
            replay_done_p1 <= 1'b0;
        end else begin
            state_p1       <= state_p0;
            pos_x_p1       <= pos_x_p0;
            pos_y_p1       <= pos_y_p0;
            count_p1       <= count_p0;
            rd_ptr_p1      <= rd_ptr_p0;
            bound_err_p1   <= bound_err_p0;
            stack_err_p1   <= stack_err_p0;
            replay_done_p1 <= replay_done_p0;
        end
    end

    // Stack storage is pure data; entries above count are never observed.
    always_ff @(posedge clk) begin
        if (push_p0) begin
            mem[count_p1[AW-1:0]] <= bus.move;
        end
    end

    assign bus.pos_x        = pos_x_p1;
    assign bus.pos_y        = pos_y_p1;
    assign bus.count        = count_p1;
    assign bus.top_move     = top_move;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.bound_err    = bound_err_p1;
    assign bus.stack_err    = stack_err_p1;
    assign bus.replay_valid = (state_p1 == REPLAY);
    assign bus.replay_move  = (state_p1 == REPLAY) ? mem[rd_ptr_p1] : 2'b00;
    assign bus.replay_done  = replay_done_p1;
endmodule

// File: tb/tb_maze_walker_datapath.sv
// Scoreboard bench for maze_walker_datapath: a queue-based mouse model predicts
// every cycle's outputs and the replayed move sequence.
module tb_maze_walker_datapath;
    localparam int COORD_W = 4;
    localparam int DEPTH   = 8;
    localparam int MAX_X   = 6;
    localparam int MAX_Y   = 5;

    typedef struct {
        int px, py, cnt, top, emp, full, be, se, vld, rmv, dn;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maze_walker_if #(.COORD_W(COORD_W), .DEPTH(DEPTH)) bus ();

    maze_walker_datapath #(
        .COORD_W(COORD_W), .DEPTH(DEPTH), .MAX_X(MAX_X), .MAX_Y(MAX_Y),
        .START_X(0), .START_Y(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   popped   = 0;
    int   m_x = 0, m_y = 0, m_mode = 0, m_rd = 0;
    int   m_stk[$];
    int   rep_q[$];
    exp_t exp_q[$];
    exp_t mon_e;

    function void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endfunction

    function int dx(input int m);
        return (m == 1) ? 1 : (m == 2) ? -1 : 0;
    endfunction

    function int dy(input int m);
        return (m == 0) ? 1 : (m == 3) ? -1 : 0;
    endfunction

    // Drive one cycle of inputs, advance the model across the coming edge and
    // queue the outputs expected after it.
    task automatic cycle(input bit r, input bit s, input int mv, input bit b,
                         input bit p, input bit rdy);
        exp_t e;
        int   nx, ny, mm;
        rst              = r;
        bus.cmd_step     = s;
        bus.move         = mv[1:0];
        bus.cmd_back     = b;
        bus.cmd_replay   = p;
        bus.replay_ready = rdy;
        e.be = 0; e.se = 0; e.dn = 0;
        if (r) begin
            m_x = 0; m_y = 0; m_mode = 0; m_rd = 0;
            m_stk.delete();
            rep_q.delete();
        end else if (m_mode == 0) begin
            if (p) begin
                if (m_stk.size() > 0) begin
                    m_mode = 1; m_rd = 0;
                    foreach (m_stk[i]) rep_q.push_back(m_stk[i]);
                end else begin
                    e.dn = 1;
                end
            end else if (b) begin
                if (m_stk.size() == 0) e.se = 1;
                else begin
                    mm  = m_stk.pop_back();
                    m_x = m_x - dx(mm);
                    m_y = m_y - dy(mm);
                end
            end else if (s) begin
                nx = m_x + dx(mv);
                ny = m_y + dy(mv);
                if (nx < 0 || nx > MAX_X || ny < 0 || ny > MAX_Y) e.be = 1;
                else if (m_stk.size() == DEPTH) e.se = 1;
                else begin
                    m_x = nx; m_y = ny;
                    m_stk.push_back(mv);
                end
            end
        end else if (rdy) begin
            m_rd++;
            if (m_rd == m_stk.size()) begin
                m_mode = 0; m_rd = 0; e.dn = 1;
            end
        end
        e.px   = m_x;
        e.py   = m_y;
        e.cnt  = m_stk.size();
        e.top  = (m_stk.size() > 0) ? m_stk[$] : 0;
        e.emp  = (m_stk.size() == 0);
        e.full = (m_stk.size() == DEPTH);
        e.vld  = m_mode;
        e.rmv  = (m_mode != 0) ? m_stk[m_rd] : 0;
        exp_q.push_back(e);
        pushed++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, rdy);
    endtask

    task automatic step(input int mv);
        cycle(0, 1, mv, 0, 0, 1'b0);
    endtask

    task automatic back();
        cycle(0, 0, 0, 1, 0, 1'b0);
    endtask

    // Per-cycle output monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                popped++;
                chk("pos_x",        int'(bus.pos_x),        mon_e.px);
                chk("pos_y",        int'(bus.pos_y),        mon_e.py);
                chk("count",        int'(bus.count),        mon_e.cnt);
                chk("top_move",     int'(bus.top_move),     mon_e.top);
                chk("empty",        int'(bus.empty),        mon_e.emp);
                chk("full",         int'(bus.full),         mon_e.full);
                chk("bound_err",    int'(bus.bound_err),    mon_e.be);
                chk("stack_err",    int'(bus.stack_err),    mon_e.se);
                chk("replay_valid", int'(bus.replay_valid), mon_e.vld);
                chk("replay_move",  int'(bus.replay_move),  mon_e.rmv);
                chk("replay_done",  int'(bus.replay_done),  mon_e.dn);
            end
        end
    end

    // Replay handshake monitor: inputs settle at negedge, so the handshake
    // about to happen at the next rising edge is visible here.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus.replay_valid && bus.replay_ready && !rst) begin
                if (rep_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL replay_extra_beat actual_move=%0d required=none", bus.replay_move);
                end else begin
                    chk("replay_seq", int'(bus.replay_move), rep_q.pop_front());
                end
            end
        end
    end

    initial begin
        int guard;
        cycle(1, 0, 0, 0, 0, 1'b0);
        cycle(1, 0, 0, 0, 0, 1'b0);
        chk("reset_pos_x", int'(bus.pos_x), 0);
        chk("reset_empty", int'(bus.empty), 1);

        step(1); step(1); step(0);
        chk("plan_step_x", int'(bus.pos_x), 2);
        chk("plan_step_y", int'(bus.pos_y), 1);
        chk("plan_step_top", int'(bus.top_move), 0);
        back(); back(); back(); back();
        chk("plan_back_x", int'(bus.pos_x), 0);
        chk("plan_back_err", int'(bus.stack_err), 1);
        idle(1, 1'b0);

        step(2);
        chk("plan_bound_lo", int'(bus.bound_err), 1);
        for (int i = 0; i < MAX_X; i++) step(1);
        step(1);
        chk("plan_bound_hi", int'(bus.bound_err), 1);
        chk("plan_bound_x", int'(bus.pos_x), MAX_X);
        for (int i = 0; i < MAX_X; i++) back();

        for (int i = 0; i < DEPTH; i++) step(i % 2);
        chk("plan_full", int'(bus.full), 1);
        step(1);
        chk("plan_full_err", int'(bus.stack_err), 1);
        chk("plan_full_count", int'(bus.count), DEPTH);
        cycle(0, 1, 1, 1, 0, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) back();

        step(1); step(0); step(2);
        cycle(0, 1, 1, 1, 1, 1'b0);
        cycle(0, 0, 0, 0, 0, 1'b1);
        cycle(0, 1, 1, 0, 0, 1'b0);
        cycle(0, 0, 0, 1, 0, 1'b1);
        cycle(0, 0, 0, 0, 1, 1'b1);
        chk("plan_replay_done", int'(bus.replay_done), 1);
        chk("plan_replay_count", int'(bus.count), 3);
        chk("plan_replay_x", int'(bus.pos_x), 0);
        back(); back(); back();
        cycle(0, 0, 0, 0, 1, 1'b1);
        chk("plan_empty_replay_done", int'(bus.replay_done), 1);
        chk("plan_empty_replay_vld", int'(bus.replay_valid), 0);

        step(1); step(0);
        cycle(0, 0, 0, 0, 1, 1'b0);
        cycle(0, 0, 0, 0, 0, 1'b1);
        cycle(1, 0, 0, 0, 0, 1'b1);
        chk("plan_midreset_count", int'(bus.count), 0);
        idle(2, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 249) == 0, $urandom_range(0, 4) < 3,
                  int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
        end

        guard = 0;
        while (m_mode != 0 && guard < DEPTH + 2) begin
            cycle(0, 0, 0, 0, 0, 1'b1);
            guard++;
        end
        idle(2, 1'b0);
        chk("replay_queue_drained", rep_q.size(), 0);
        chk("scoreboard_drained", popped, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
